// File: rtl/ddr3_client_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing the single-beat 128-bit DDR3 bridge command
// port between NUM_CLIENTS pipeline requesters. One command is outstanding
// at a time; a watchdog aborts a command the bridge never completes.
//
// Client handshake: a client raises cli_req with cli_wr/cli_addr/cli_wdata
// stable and keeps them stable until it samples its cli_ack bit high. It
// drops (or replaces) the request on that same edge. cli_ack is a one-cycle
// one-hot pulse, and cli_rdata is valid while it is high (held afterwards).
module ddr3_client_arbiter #(
  parameter int NUM_CLIENTS    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        main_clk,
  input  logic                        main_reset,
  input  logic [NUM_CLIENTS-1:0]      cli_req,
  input  logic [NUM_CLIENTS-1:0]      cli_wr,
  input  logic [32*NUM_CLIENTS-1:0]   cli_addr,
  input  logic [128*NUM_CLIENTS-1:0]  cli_wdata,
  output logic [NUM_CLIENTS-1:0]      cli_ack,
  output logic [127:0]                cli_rdata,
  output logic                        rd_en,
  output logic                        wr_en,
  output logic [31:0]                 sdram_address,
  output logic [127:0]                write_data_input,
  input  logic [127:0]                read_data,
  input  logic                        read_complete,
  input  logic                        write_complete,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [1:0]                  fsm_state
);

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt;
  logic          gnt_wr;
  logic [31:0]   wd_cnt;
  logic [PW-1:0] pick;
  logic [PW-1:0] cand;
  logic          pick_valid;
  logic          cmd_done;

  // Debug view of the FSM state (already a register).
  assign fsm_state = state;

  // Only the completion that matches the issued command type counts.
  assign cmd_done = gnt_wr ? write_complete : read_complete;

  // Round-robin search: first requester strictly after rr_ptr, wrapping.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_valid = 1'b0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_CLIENTS);
      if (!pick_valid && cli_req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Command FSM with registered bridge and client outputs.
  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      state            <= IDLE;
      rr_ptr           <= PW'(NUM_CLIENTS - 1);
      gnt              <= '0;
      gnt_wr           <= 1'b0;
      wd_cnt           <= '0;
      cli_ack          <= '0;
      cli_rdata        <= '0;
      rd_en            <= 1'b0;
      wr_en            <= 1'b0;
      sdram_address    <= '0;
      write_data_input <= '0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      // Pulses default low; address/data hold until the next grant.
      cli_ack <= '0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt              <= pick;
            gnt_wr           <= cli_wr[pick];
            rd_en            <= !cli_wr[pick];
            wr_en            <= cli_wr[pick];
            sdram_address    <= cli_addr[32*pick +: 32];
            write_data_input <= cli_wr[pick] ? cli_wdata[128*pick +: 128] : '0;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          // The command pulse is visible during this single cycle.
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (cmd_done) begin
            if (!gnt_wr) cli_rdata <= read_data;
            rr_ptr       <= gnt;
            cli_ack[gnt] <= 1'b1;
            state        <= DONE;
          end else if (TIMEOUT_CYCLES != 0 &&
                       (wd_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
            // Abort without ack; the still-requesting client is retried.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
